spi_reg_bank: RTL and testbench

- Parametrised SPI register decoder and configuration bank between soft_spi_slave and the DSP datapath.
- Next generation of the top-level register handling:
  - configurable address and data width;
  - N_CH independent coefficient banks and shift registers;
  - handshaked coefficient read and write, with timeout;
  - sticky error and status reporting;
  - a saturating measurement counter.
- Drives the FIR configuration ports plus soft-reset and flush pulses; owns spi_data_tx.

---
 rtl/spi_reg_pkg.sv | 22 ++
 rtl/reg_pulse_stretch.sv | 28 ++
 rtl/spi_reg_bank.sv | 249 ++++++++++++++++++++++++
 tb/tb_spi_reg_bank.sv | 564 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_reg_pkg.sv
// Shared constants for the SPI register bank: register addresses, STATUS bit
// positions and the coefficient handshake state encoding.
package spi_reg_pkg;

    localparam int ADDR_CTRL       = 8'h00;
    localparam int ADDR_SHIFT_BASE = 8'h01;
    localparam int ADDR_STATUS     = 8'h08;
    localparam int ADDR_MEAS_CNT   = 8'h09;
    localparam int ADDR_ID         = 8'h3F;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_TIMEOUT = 1;
    localparam int STAT_OVERRUN = 2;
    localparam int STAT_BADADDR = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_WAIT = 2'd1,
        ST_WR_WAIT = 2'd2
    } state_t;

endpackage

// File: rtl/reg_pulse_stretch.sv
// Retriggerable pulse generator: a trigger holds the output high for exactly
// PULSE_LEN cycles, restarting the count if it arrives while already high.
module reg_pulse_stretch #(
    parameter int PULSE_LEN = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic trigger,
    output logic pulse
);

    localparam int CNT_W = $clog2(PULSE_LEN + 1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (trigger) begin
            cnt_q <= CNT_W'(PULSE_LEN);
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign pulse = (cnt_q != '0);

endmodule

// File: rtl/spi_reg_bank.sv
// SPI register decoder and configuration bank: control pulses, per-channel
// shifts, sticky status, measurement counter and handshaked coefficient access.
module spi_reg_bank
    import spi_reg_pkg::*;
#(
    parameter int ADDR_W      = 7,
    parameter int DATA_W      = 24,
    parameter int COEF_IDX_W  = 4,
    parameter int N_CH        = 2,
    parameter int SHIFT_W     = 5,
    parameter int PULSE_LEN   = 2,
    parameter int ACK_TIMEOUT = 15,
    parameter logic [DATA_W-1:0] DEVICE_ID = DATA_W'(24'hF0CCAB),
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_W-1:0]       spi_addr,
    input  logic                    spi_addr_rdy,
    input  logic                    spi_rw,
    input  logic [DATA_W-1:0]       spi_data,
    input  logic                    spi_data_rdy,
    output logic [DATA_W-1:0]       spi_data_tx,
    output logic                    soft_rst,
    output logic                    fir_flush,
    output logic [CH_W-1:0]         coef_ch,
    output logic [COEF_IDX_W-1:0]   coef_idx,
    output logic [DATA_W-1:0]       coef_wdata,
    output logic                    coef_req,
    output logic                    coef_we,
    input  logic                    coef_ack,
    input  logic [DATA_W-1:0]       coef_rdata,
    output logic [N_CH*SHIFT_W-1:0] shift_out,
    input  logic                    meas_done
);

    localparam int TMR_W = $clog2(ACK_TIMEOUT + 1);

    if (1 + CH_W + COEF_IDX_W > ADDR_W) begin : g_cfg_check
        $error("spi_reg_bank: ADDR_W too narrow for channel and index fields");
    end

    state_t state_q, state_d;

    logic addr_rdy_q, addr_rdy_q2, data_rdy_q, data_rdy_q2;
    logic addr_edge, data_edge;
    logic [TMR_W-1:0] timer_q;
    logic [SHIFT_W-1:0] shift_q [N_CH];
    logic [3:0] err_q, err_set, err_clr;
    logic [DATA_W-1:0] meas_cnt_q;
    logic rd_pend_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic [DATA_W-1:0] rd_val;

    int addr_val, rd_addr_val;
    logic is_coef, ch_ok, reg_ok, idle;
    logic [CH_W-1:0] a_ch;
    logic [COEF_IDX_W-1:0] a_idx;
    logic rd_coef_start, wr_coef_start, rd_reg, wr_reg, wr_bad_coef;
    logic bad_evt, overrun_evt, timeout_evt;
    logic soft_trig, flush_trig, meas_clr;

    // The edge is taken from the registered copy, so it is acted on one cycle after sampling.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_rdy_q  <= 1'b0;
            addr_rdy_q2 <= 1'b0;
            data_rdy_q  <= 1'b0;
            data_rdy_q2 <= 1'b0;
        end else begin
            addr_rdy_q  <= spi_addr_rdy;
            addr_rdy_q2 <= addr_rdy_q;
            data_rdy_q  <= spi_data_rdy;
            data_rdy_q2 <= data_rdy_q;
        end
    end

    assign addr_edge = addr_rdy_q & ~addr_rdy_q2;
    assign data_edge = data_rdy_q & ~data_rdy_q2;

    assign addr_val = int'(spi_addr);
    assign is_coef  = spi_addr[ADDR_W-1];
    assign a_ch     = spi_addr[COEF_IDX_W +: CH_W];
    assign a_idx    = spi_addr[COEF_IDX_W-1:0];
    assign ch_ok    = int'(a_ch) < N_CH;
    assign idle     = (state_q == ST_IDLE);

    always_comb begin
        reg_ok = 1'b0;
        if (addr_val == ADDR_CTRL || addr_val == ADDR_STATUS ||
            addr_val == ADDR_MEAS_CNT || addr_val == ADDR_ID) begin
            reg_ok = 1'b1;
        end
        if (addr_val >= ADDR_SHIFT_BASE && addr_val < ADDR_SHIFT_BASE + N_CH) begin
            reg_ok = 1'b1;
        end
    end

    // A coefficient read to a missing channel goes through the register read path and returns 0.
    assign rd_coef_start = idle & addr_edge &  spi_rw &  is_coef & ch_ok;
    assign wr_coef_start = idle & data_edge & ~spi_rw &  is_coef & ch_ok;
    assign rd_reg        = idle & addr_edge &  spi_rw & ~(is_coef & ch_ok);
    assign wr_reg        = idle & data_edge & ~spi_rw & ~is_coef;
    assign wr_bad_coef   = idle & data_edge & ~spi_rw &  is_coef & ~ch_ok;

    assign bad_evt     = (rd_reg | wr_reg | wr_bad_coef) & ~(~is_coef & reg_ok);
    assign overrun_evt = ~idle & (addr_edge | data_edge);
    assign timeout_evt = ~idle & ~coef_ack & (timer_q == TMR_W'(ACK_TIMEOUT - 1));

    assign soft_trig  = wr_reg & (addr_val == ADDR_CTRL) & spi_data[0];
    assign flush_trig = wr_reg & (addr_val == ADDR_CTRL) & spi_data[1];
    assign meas_clr   = wr_reg & (addr_val == ADDR_MEAS_CNT);

    always_comb begin
        err_set               = '0;
        err_set[STAT_TIMEOUT] = timeout_evt;
        err_set[STAT_OVERRUN] = overrun_evt;
        err_set[STAT_BADADDR] = bad_evt;
        err_clr               = '0;
        if (wr_reg && addr_val == ADDR_STATUS) begin
            err_clr = {spi_data[3:1], 1'b0};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Ack is checked before the timer, so an ack on the final cycle wins.
    always_comb begin
        state_d  = state_q;
        coef_req = 1'b0;
        coef_we  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (rd_coef_start) begin
                    state_d = ST_RD_WAIT;
                end else if (wr_coef_start) begin
                    state_d = ST_WR_WAIT;
                end
            end
            ST_RD_WAIT, ST_WR_WAIT: begin
                coef_req = 1'b1;
                coef_we  = (state_q == ST_WR_WAIT);
                if (coef_ack || timeout_evt) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_q <= '0;
        end else if (idle) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_q + 1'b1;
        end
    end

    assign rd_addr_val = int'(rd_addr_q);

    always_comb begin
        rd_val = '0;
        if (rd_addr_val == ADDR_STATUS) begin
            rd_val[3:0] = err_q | {3'b000, ~idle};
        end else if (rd_addr_val == ADDR_MEAS_CNT) begin
            rd_val = meas_cnt_q;
        end else if (rd_addr_val == ADDR_ID) begin
            rd_val = DEVICE_ID;
        end
        for (int c = 0; c < N_CH; c++) begin
            if (rd_addr_val == ADDR_SHIFT_BASE + c) begin
                rd_val[SHIFT_W-1:0] = shift_q[c];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            spi_data_tx <= '0;
            rd_pend_q   <= 1'b0;
            rd_addr_q   <= '0;
            coef_ch     <= '0;
            coef_idx    <= '0;
            coef_wdata  <= '0;
            err_q       <= '0;
            meas_cnt_q  <= '0;
            for (int c = 0; c < N_CH; c++) begin
                shift_q[c] <= '0;
            end
        end else begin
            rd_pend_q <= rd_reg;
            if (rd_reg) begin
                rd_addr_q <= spi_addr;
            end
            if (rd_pend_q) begin
                spi_data_tx <= rd_val;
            end else if (state_q == ST_RD_WAIT && coef_ack) begin
                spi_data_tx <= coef_rdata;
            end else if (state_q == ST_RD_WAIT && timeout_evt) begin
                spi_data_tx <= '0;
            end
            if (rd_coef_start || wr_coef_start) begin
                coef_ch  <= a_ch;
                coef_idx <= a_idx;
            end
            if (wr_coef_start) begin
                coef_wdata <= spi_data;
            end
            for (int c = 0; c < N_CH; c++) begin
                if (wr_reg && addr_val == ADDR_SHIFT_BASE + c) begin
                    shift_q[c] <= spi_data[SHIFT_W-1:0];
                end
            end
            err_q <= (err_q & ~err_clr) | err_set;
            if (meas_clr) begin
                meas_cnt_q <= meas_done ? DATA_W'(1) : '0;
            end else if (meas_done && meas_cnt_q != '1) begin
                meas_cnt_q <= meas_cnt_q + 1'b1;
            end
        end
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_shift_out
        assign shift_out[c*SHIFT_W +: SHIFT_W] = shift_q[c];
    end

    reg_pulse_stretch #(.PULSE_LEN(PULSE_LEN)) u_soft_rst (
        .clk     (clk),
        .rst     (rst),
        .trigger (soft_trig),
        .pulse   (soft_rst)
    );

    reg_pulse_stretch #(.PULSE_LEN(PULSE_LEN)) u_fir_flush (
        .clk     (clk),
        .rst     (rst),
        .trigger (flush_trig),
        .pulse   (fir_flush)
    );

endmodule

// File: tb/tb_spi_reg_bank.sv
// Self-checking bench for spi_reg_bank: a 24-bit instance with a FIR responder,
// plus an 8-bit instance sharing the stimulus for counter saturation and ID width.
module tb_spi_reg_bank;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [6:0]  spi_addr;
    logic        spi_addr_rdy;
    logic        spi_rw;
    logic [23:0] spi_data;
    logic        spi_data_rdy;
    logic [23:0] spi_data_tx;
    logic        soft_rst, fir_flush;
    logic [0:0]  coef_ch;
    logic [3:0]  coef_idx;
    logic [23:0] coef_wdata;
    logic        coef_req, coef_we;
    logic        coef_ack;
    logic [23:0] coef_rdata;
    logic [9:0]  shift_out;
    logic        meas_done;

    logic [7:0]  tx8;
    logic        soft_rst8, fir_flush8;
    logic [0:0]  coef_ch8;
    logic [3:0]  coef_idx8;
    logic [7:0]  coef_wdata8;
    logic        coef_req8, coef_we8;
    logic [9:0]  shift_out8;

    int tests_run = 0;
    int tests_failed = 0;

    spi_reg_bank dut (
        .clk(clk), .rst(rst), .spi_addr(spi_addr), .spi_addr_rdy(spi_addr_rdy),
        .spi_rw(spi_rw), .spi_data(spi_data), .spi_data_rdy(spi_data_rdy),
        .spi_data_tx(spi_data_tx), .soft_rst(soft_rst), .fir_flush(fir_flush),
        .coef_ch(coef_ch), .coef_idx(coef_idx), .coef_wdata(coef_wdata),
        .coef_req(coef_req), .coef_we(coef_we), .coef_ack(coef_ack),
        .coef_rdata(coef_rdata), .shift_out(shift_out), .meas_done(meas_done)
    );

    spi_reg_bank #(.DATA_W(8), .DEVICE_ID(8'hAB)) dut8 (
        .clk(clk), .rst(rst), .spi_addr(spi_addr), .spi_addr_rdy(spi_addr_rdy),
        .spi_rw(spi_rw), .spi_data(spi_data[7:0]), .spi_data_rdy(spi_data_rdy),
        .spi_data_tx(tx8), .soft_rst(soft_rst8), .fir_flush(fir_flush8),
        .coef_ch(coef_ch8), .coef_idx(coef_idx8), .coef_wdata(coef_wdata8),
        .coef_req(coef_req8), .coef_we(coef_we8), .coef_ack(coef_ack),
        .coef_rdata(coef_rdata[7:0]), .shift_out(shift_out8), .meas_done(meas_done)
    );

    // FIR-side responder: acks after ack_delay cycles of request, backed by its own memory.
    logic        ack_enable = 1'b0;
    int          ack_delay = 0;
    logic        rdata_ovr_en = 1'b0;
    logic [23:0] rdata_ovr = '0;
    logic [23:0] fir_mem [2][16];
    logic [0:0]  seen_ch = '0;
    logic [3:0]  seen_idx = '0;
    logic        seen_we = 1'b0;
    logic [23:0] seen_wdata = '0;

    initial begin : responder
        int wait_cnt;
        wait_cnt   = 0;
        coef_ack   = 1'b0;
        coef_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (coef_ack) begin
                coef_ack = 1'b0;
                wait_cnt = 0;
            end else if (coef_req && ack_enable) begin
                if (wait_cnt >= ack_delay) begin
                    coef_ack   = 1'b1;
                    seen_ch    = coef_ch;
                    seen_idx   = coef_idx;
                    seen_we    = coef_we;
                    seen_wdata = coef_wdata;
                    if (coef_we) fir_mem[coef_ch][coef_idx] = coef_wdata;
                    coef_rdata = rdata_ovr_en ? rdata_ovr : fir_mem[coef_ch][coef_idx];
                    wait_cnt   = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        spi_addr_rdy = 1'b0;
        spi_data_rdy = 1'b0;
        meas_done = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic reg_write(input logic [6:0] a, input logic [23:0] d);
        spi_addr = a;
        spi_rw = 1'b0;
        spi_addr_rdy = 1'b1;
        tick();
        spi_data = d;
        spi_data_rdy = 1'b1;
        tick();
        spi_addr_rdy = 1'b0;
        spi_data_rdy = 1'b0;
        repeat (3) tick();
    endtask

    task automatic reg_read(input logic [6:0] a, output logic [23:0] d, output logic [7:0] d8);
        spi_addr = a;
        spi_rw = 1'b1;
        spi_addr_rdy = 1'b1;
        repeat (4) tick();
        d = spi_data_tx;
        d8 = tx8;
        spi_addr_rdy = 1'b0;
        tick();
        tick();
    endtask

    task automatic wait_req_low(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 60; n++) begin
            if (!coef_req) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic coef_read(input logic [6:0] a, output logic [23:0] d, output bit ok);
        spi_addr = a;
        spi_rw = 1'b1;
        spi_addr_rdy = 1'b1;
        repeat (3) tick();
        wait_req_low(ok);
        tick();
        d = spi_data_tx;
        spi_addr_rdy = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        logic [23:0] d;
        logic [7:0] d8;
        rst = 1'b1;
        tick();
        tests_run++;
        if ({spi_data_tx, soft_rst, fir_flush, coef_req, coef_we} !== 28'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_outputs: got tx=%h sr=%b ff=%b req=%b we=%b expected all 0",
                     spi_data_tx, soft_rst, fir_flush, coef_req, coef_we);
        end
        tests_run++;
        if ({shift_out, coef_wdata, coef_ch, coef_idx} !== 39'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_config: got shift=%h wdata=%h ch=%h idx=%h expected 0",
                     shift_out, coef_wdata, coef_ch, coef_idx);
        end
        rst = 1'b0;
        tick();
        reg_read(7'h08, d, d8);
        tests_run++;
        if (d !== 24'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_status: got %h expected 000000", d);
        end
    endtask

    task automatic test_ctrl_pulse();
        int sr_cnt = 0, ff_cnt = 0, sr_first = -1, ff_first = -1;
        logic [23:0] d;
        logic [7:0] d8;
        spi_addr = 7'h00;
        spi_rw = 1'b0;
        spi_addr_rdy = 1'b1;
        tick();
        spi_data = 24'h000003;
        spi_data_rdy = 1'b1;
        tick();
        spi_addr_rdy = 1'b0;
        spi_data_rdy = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (soft_rst) begin
                sr_cnt++;
                if (sr_first < 0) sr_first = i;
            end
            if (fir_flush) begin
                ff_cnt++;
                if (ff_first < 0) ff_first = i;
            end
        end
        tests_run++;
        if (sr_cnt != 2) begin
            tests_failed++;
            $display("[TB] FAIL soft_rst_len: got %0d cycles expected 2", sr_cnt);
        end
        tests_run++;
        if (ff_cnt != 2) begin
            tests_failed++;
            $display("[TB] FAIL fir_flush_len: got %0d cycles expected 2", ff_cnt);
        end
        tests_run++;
        if (sr_first != ff_first || sr_first < 0) begin
            tests_failed++;
            $display("[TB] FAIL pulse_align: got starts %0d/%0d expected equal", sr_first, ff_first);
        end
        reg_read(7'h00, d, d8);
        tests_run++;
        if (d !== 24'h0) begin
            tests_failed++;
            $display("[TB] FAIL ctrl_read: got %h expected 000000", d);
        end
    endtask

    task automatic test_shift();
        logic [23:0] d;
        logic [7:0] d8;
        reg_write(7'h02, 24'h00001F);
        tests_run++;
        if (shift_out !== 10'h3E0) begin
            tests_failed++;
            $display("[TB] FAIL shift_out: got %h expected 3e0", shift_out);
        end
        reg_read(7'h02, d, d8);
        tests_run++;
        if (d !== 24'h00001F) begin
            tests_failed++;
            $display("[TB] FAIL shift_read: got %h expected 00001f", d);
        end
    endtask

    task automatic test_coef();
        logic [23:0] d;
        bit ok;
        ack_enable = 1'b1;
        ack_delay = 3;
        reg_write(7'h55, 24'h123456);
        wait_req_low(ok);
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("[TB] FAIL coef_wr_done: got req stuck expected release");
        end
        tests_run++;
        if ({seen_ch, seen_idx, seen_we, seen_wdata} !== {1'b1, 4'd5, 1'b1, 24'h123456}) begin
            tests_failed++;
            $display("[TB] FAIL coef_wr_fields: got ch=%h idx=%h we=%b wdata=%h expected 1 5 1 123456",
                     seen_ch, seen_idx, seen_we, seen_wdata);
        end
        rdata_ovr_en = 1'b1;
        rdata_ovr = 24'hABCDEF;
        coef_read(7'h55, d, ok);
        rdata_ovr_en = 1'b0;
        tests_run++;
        if (!ok || d !== 24'hABCDEF || seen_we !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL coef_rd: got ok=%b tx=%h we=%b expected 1 abcdef 0", ok, d, seen_we);
        end
    endtask

    task automatic test_timeout();
        logic [23:0] d;
        logic [7:0] d8;
        int req_cnt = 0;
        ack_enable = 1'b0;
        reg_read(7'h3F, d, d8);
        spi_addr = 7'h41;
        spi_rw = 1'b1;
        spi_addr_rdy = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (coef_req) req_cnt++;
        end
        tests_run++;
        if (req_cnt != 15) begin
            tests_failed++;
            $display("[TB] FAIL timeout_len: got %0d cycles expected 15", req_cnt);
        end
        tests_run++;
        if (spi_data_tx !== 24'h0) begin
            tests_failed++;
            $display("[TB] FAIL timeout_tx: got %h expected 000000", spi_data_tx);
        end
        spi_addr_rdy = 1'b0;
        tick();
        tick();
        reg_read(7'h08, d, d8);
        tests_run++;
        if (d !== 24'h2) begin
            tests_failed++;
            $display("[TB] FAIL timeout_status: got %h expected 000002", d);
        end
        reg_write(7'h08, 24'h2);
        reg_read(7'h08, d, d8);
        tests_run++;
        if (d !== 24'h0) begin
            tests_failed++;
            $display("[TB] FAIL status_clear: got %h expected 000000", d);
        end
    endtask

    task automatic test_overrun_reset();
        logic [23:0] d;
        logic [7:0] d8;
        bit ok;
        ack_enable = 1'b1;
        ack_delay = 10;
        reg_write(7'h43, 24'h0000AA);
        reg_read(7'h01, d, d8);
        wait_req_low(ok);
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("[TB] FAIL overrun_done: got req stuck expected release");
        end
        reg_read(7'h08, d, d8);
        tests_run++;
        if (d !== 24'h4) begin
            tests_failed++;
            $display("[TB] FAIL overrun_status: got %h expected 000004", d);
        end
        ack_enable = 1'b0;
        reg_write(7'h50, 24'h000777);
        tests_run++;
        if (coef_req !== 1'b1 || coef_we !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL wr_wait_entry: got req=%b we=%b expected 1 1", coef_req, coef_we);
        end
        rst = 1'b1;
        #1;
        tests_run++;
        if (coef_req !== 1'b0 || coef_we !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_abort: got req=%b we=%b expected 0 0", coef_req, coef_we);
        end
        tick();
        rst = 1'b0;
        tick();
        reg_read(7'h08, d, d8);
        tests_run++;
        if (d !== 24'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_no_error: got %h expected 000000", d);
        end
    endtask

    task automatic test_meas_id();
        logic [23:0] d;
        logic [7:0] d8;
        do_reset();
        repeat (300) begin
            meas_done = 1'b1;
            tick();
            meas_done = 1'b0;
            tick();
        end
        reg_read(7'h09, d, d8);
        tests_run++;
        if (d !== 24'd300 || d8 !== 8'hFF) begin
            tests_failed++;
            $display("[TB] FAIL meas_count: got %h/%h expected 00012c/ff", d, d8);
        end
        spi_addr = 7'h09;
        spi_rw = 1'b0;
        spi_addr_rdy = 1'b1;
        tick();
        spi_data = 24'h0;
        spi_data_rdy = 1'b1;
        tick();
        meas_done = 1'b1;
        tick();
        meas_done = 1'b0;
        spi_addr_rdy = 1'b0;
        spi_data_rdy = 1'b0;
        tick();
        tick();
        reg_read(7'h09, d, d8);
        tests_run++;
        if (d !== 24'd1 || d8 !== 8'd1) begin
            tests_failed++;
            $display("[TB] FAIL meas_clr_collide: got %h/%h expected 000001/01", d, d8);
        end
        reg_read(7'h3F, d, d8);
        tests_run++;
        if (d !== 24'hF0CCAB || d8 !== 8'hAB) begin
            tests_failed++;
            $display("[TB] FAIL device_id: got %h/%h expected f0ccab/ab", d, d8);
        end
        reg_read(7'h20, d, d8);
        tests_run++;
        if (d !== 24'h0 || d8 !== 8'h0) begin
            tests_failed++;
            $display("[TB] FAIL bad_addr_read: got %h/%h expected 0/0", d, d8);
        end
        reg_read(7'h08, d, d8);
        tests_run++;
        if (d !== 24'h8 || d8 !== 8'h8) begin
            tests_failed++;
            $display("[TB] FAIL bad_addr_status: got %h/%h expected 000008/08", d, d8);
        end
    endtask

    // Random register/coefficient traffic against a plain array-and-counter model.
    task automatic test_random();
        logic [4:0]  shift_m [2];
        logic [23:0] coef_m [2][16];
        int          meas_m;
        logic [3:0]  sticky_m;
        logic [23:0] d, v;
        logic [7:0]  d8;
        logic [6:0]  a;
        bit ok;
        int op, ch, idx, k;
        do_reset();
        for (int c = 0; c < 2; c++) begin
            shift_m[c] = '0;
            for (int i = 0; i < 16; i++) begin
                coef_m[c][i] = '0;
                fir_mem[c][i] = '0;
            end
        end
        meas_m = 0;
        sticky_m = '0;
        ack_enable = 1'b1;
        rdata_ovr_en = 1'b0;
        for (int it = 0; it < 40; it++) begin
            op = $urandom_range(0, 8);
            ch = $urandom_range(0, 1);
            idx = $urandom_range(0, 15);
            v = 24'($urandom);
            case (op)
                0: begin
                    reg_write(7'(1 + ch), v);
                    shift_m[ch] = v[4:0];
                    tests_run++;
                    if (shift_out !== {shift_m[1], shift_m[0]}) begin
                        tests_failed++;
                        $display("[TB] FAIL rnd_shift_out: got %h expected %h", shift_out, {shift_m[1], shift_m[0]});
                    end
                end
                1: begin
                    reg_read(7'(1 + ch), d, d8);
                    tests_run++;
                    if (d !== {19'h0, shift_m[ch]}) begin
                        tests_failed++;
                        $display("[TB] FAIL rnd_shift_rd: got %h expected %h", d, shift_m[ch]);
                    end
                end
                2: begin
                    ack_delay = $urandom_range(0, 5);
                    reg_write(7'(64 + ch * 16 + idx), v);
                    wait_req_low(ok);
                    coef_m[ch][idx] = v;
                    tests_run++;
                    if (!ok || seen_we !== 1'b1 || seen_wdata !== v || int'(seen_ch) != ch || int'(seen_idx) != idx) begin
                        tests_failed++;
                        $display("[TB] FAIL rnd_coef_wr: got ok=%b we=%b %h@%0d/%0d expected %h@%0d/%0d",
                                 ok, seen_we, seen_wdata, seen_ch, seen_idx, v, ch, idx);
                    end
                end
                3: begin
                    ack_delay = $urandom_range(0, 5);
                    coef_read(7'(64 + ch * 16 + idx), d, ok);
                    tests_run++;
                    if (!ok || d !== coef_m[ch][idx]) begin
                        tests_failed++;
                        $display("[TB] FAIL rnd_coef_rd: got ok=%b %h expected %h", ok, d, coef_m[ch][idx]);
                    end
                end
                4: begin
                    k = $urandom_range(1, 20);
                    repeat (k) begin
                        meas_done = 1'b1;
                        tick();
                        meas_done = 1'b0;
                        tick();
                    end
                    meas_m += k;
                end
                5: begin
                    reg_read(7'h09, d, d8);
                    tests_run++;
                    if (d !== 24'(meas_m)) begin
                        tests_failed++;
                        $display("[TB] FAIL rnd_meas: got %h expected %h", d, 24'(meas_m));
                    end
                end
                6: begin
                    a = ($urandom_range(0, 1) == 1) ? 7'($urandom_range(3, 7)) : 7'($urandom_range(10, 62));
                    reg_read(a, d, d8);
                    sticky_m[3] = 1'b1;
                    tests_run++;
                    if (d !== 24'h0) begin
                        tests_failed++;
                        $display("[TB] FAIL rnd_bad_rd: got %h expected 000000 at %h", d, a);
                    end
                end
                7: begin
                    reg_read(7'h08, d, d8);
                    tests_run++;
                    if (d !== {20'h0, sticky_m}) begin
                        tests_failed++;
                        $display("[TB] FAIL rnd_status: got %h expected %h", d, sticky_m);
                    end
                    reg_write(7'h08, v);
                    sticky_m = sticky_m & ~{v[3:1], 1'b0};
                end
                default: begin
                    reg_write(7'h09, v);
                    meas_m = 0;
                end
            endcase
        end
        reg_read(7'h08, d, d8);
        tests_run++;
        if (d !== {20'h0, sticky_m}) begin
            tests_failed++;
            $display("[TB] FAIL rnd_status_end: got %h expected %h", d, sticky_m);
        end
    endtask

    initial begin
        rst = 1'b1;
        spi_addr = '0;
        spi_addr_rdy = 1'b0;
        spi_rw = 1'b0;
        spi_data = '0;
        spi_data_rdy = 1'b0;
        meas_done = 1'b0;
        for (int c = 0; c < 2; c++) begin
            for (int i = 0; i < 16; i++) fir_mem[c][i] = '0;
        end
        test_reset();
        test_ctrl_pulse();
        test_shift();
        test_coef();
        test_timeout();
        test_overrun_reset();
        test_meas_id();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
